// File: rtl/accumulator_seg_pkg.sv
// Shared constants for the segmented accumulator: default geometry and wrap counter width.
// Optional wrap counter is enabled by ACC_SEG_WRAP_COUNT_EN.
package acc_seg_pkg;

  localparam int ACC_SEG_DEF_SEG_WIDTH = 4;
  localparam int ACC_SEG_DEF_NSEG      = 4;
  localparam int ACC_SEG_DEF_ADD_WIDTH = 1;
  localparam int ACC_SEG_WRAP_CNT_W    = 8;

endpackage

// File: rtl/accumulator_seg_slice.sv
// One accumulator segment: segment register plus its registered carry-out.
// Latency: one edge from carry_in/add_in to seg and carry_out; no backpressure.
module acc_seg_slice
  import acc_seg_pkg::*;
#(
  parameter int SEG_WIDTH = ACC_SEG_DEF_SEG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [SEG_WIDTH-1:0] load_value,
  input  logic                 carry_in,
  input  logic [SEG_WIDTH-1:0] add_in,
  output logic [SEG_WIDTH-1:0] seg,
  output logic                 carry_out
);

  // add_in and carry_in are never both nonzero, but the sum fits SEG_WIDTH+1 bits either way
  logic [SEG_WIDTH:0] sum;

  assign sum = {1'b0, seg} + {1'b0, add_in} + {{SEG_WIDTH{1'b0}}, carry_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg       <= '0;
      carry_out <= 1'b0;
    end else if (clr) begin
      seg       <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      seg       <= load_value;
      carry_out <= 1'b0;
    end else begin
      seg       <= sum[SEG_WIDTH-1:0];
      carry_out <= sum[SEG_WIDTH];
    end
  end

endmodule

// File: rtl/accumulator_seg.sv
// Accumulator with a pipelined, registered carry chain between segments; one-segment critical path.
// Carry from seg0 reaches seg[i] i edges later; optional wrap_count under ACC_SEG_WRAP_COUNT_EN.
module accumulator_seg
  import acc_seg_pkg::*;
#(
  parameter int SEG_WIDTH = ACC_SEG_DEF_SEG_WIDTH,
  parameter int NSEG      = ACC_SEG_DEF_NSEG,
  parameter int ADD_WIDTH = ACC_SEG_DEF_ADD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [ADD_WIDTH-1:0]      add_value,
  input  logic                      clr,
  input  logic                      load,
  input  logic [SEG_WIDTH*NSEG-1:0] load_value,
  output logic [SEG_WIDTH*NSEG-1:0] data,
  output logic                      msb,
  output logic                      settled,
`ifdef ACC_SEG_WRAP_COUNT_EN
  output logic [ACC_SEG_WRAP_CNT_W-1:0] wrap_count,
`endif
  output logic                      wrap
);

  localparam int ACC_WIDTH = SEG_WIDTH * NSEG;

  logic [NSEG-1:0]      carry;
  logic [SEG_WIDTH-1:0] add0;

  assign add0 = en ? SEG_WIDTH'(add_value) : '0;

  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    if (i == 0) begin : g_lsb
      acc_seg_slice #(.SEG_WIDTH(SEG_WIDTH)) u_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load),
        .load_value (load_value[i*SEG_WIDTH +: SEG_WIDTH]),
        .carry_in   (1'b0),
        .add_in     (add0),
        .seg        (data[i*SEG_WIDTH +: SEG_WIDTH]),
        .carry_out  (carry[i])
      );
    end else begin : g_upper
      acc_seg_slice #(.SEG_WIDTH(SEG_WIDTH)) u_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load),
        .load_value (load_value[i*SEG_WIDTH +: SEG_WIDTH]),
        .carry_in   (carry[i-1]),
        .add_in     ('0),
        .seg        (data[i*SEG_WIDTH +: SEG_WIDTH]),
        .carry_out  (carry[i])
      );
    end
  end

  // The top slice's carry register is the wrap pulse, not a pending carry
  assign wrap    = carry[NSEG-1];
  assign settled = ~|carry[NSEG-2:0];
  assign msb     = data[ACC_WIDTH-1];

`ifdef ACC_SEG_WRAP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_count <= '0;
    end else if (clr) begin
      wrap_count <= '0;
    end else if (wrap && (wrap_count != '1)) begin
      wrap_count <= wrap_count + ACC_SEG_WRAP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_accumulator_seg.sv
// Scoreboard bench for accumulator_seg: expectations queued with stimulus, popped after each edge.
// A second instance with ADD_WIDTH=4 covers the wide-increment case.
module tb_accumulator_seg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [0:0]  add_value = 1'b1;
  logic [3:0]  add_value4 = 4'h0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0;
  logic [15:0] data, data4;
  logic        msb, msb4, settled, settled4, wrap, wrap4;
`ifdef ACC_SEG_WRAP_COUNT_EN
  logic [7:0]  wrap_count, wrap_count4;
`endif

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        settled;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  accumulator_seg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .add_value  (add_value),
    .clr        (clr),
    .load       (load),
    .load_value (load_value),
    .data       (data),
    .msb        (msb),
    .settled    (settled),
`ifdef ACC_SEG_WRAP_COUNT_EN
    .wrap_count (wrap_count),
`endif
    .wrap       (wrap)
  );

  accumulator_seg #(.ADD_WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .add_value  (add_value4),
    .clr        (clr),
    .load       (load),
    .load_value (load_value),
    .data       (data4),
    .msb        (msb4),
    .settled    (settled4),
`ifdef ACC_SEG_WRAP_COUNT_EN
    .wrap_count (wrap_count4),
`endif
    .wrap       (wrap4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [15:0] d, input logic s, input logic w);
    exp_t e;
    e.name = name; e.data = d; e.settled = s; e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic do_clear();
    clr = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    #2;
    push("reset_initial", 16'h0000, 1'b1, 1'b0);
    e = sb.pop_front();
    n_tests += 3;
    if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
    if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
    if (wrap !== e.wrap) begin n_fail++; $display("FAIL %s wrap got %b want %b", e.name, wrap, e.wrap); end
    tick();
    rst_n = 1'b1;
    tick();
    // Build pending carries: 0xFFFF + 1 leaves carries in flight
    load = 1'b1; load_value = 16'hFFFF;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    n_tests++;
    if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_pending settled got %b want 0", settled); end
    rst_n = 1'b0;
    #1;
    push("reset_async", 16'h0000, 1'b1, 1'b0);
    e = sb.pop_front();
    n_tests += 3;
    if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
    if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
    if (wrap !== e.wrap) begin n_fail++; $display("FAIL %s wrap got %b want %b", e.name, wrap, e.wrap); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) push("reset_no_wrap", 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      e = sb.pop_front();
      n_tests += 2;
      if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
      if (wrap !== e.wrap) begin n_fail++; $display("FAIL %s wrap got %b want %b", e.name, wrap, e.wrap); end
    end
  endtask

  task automatic test_carry_pipeline();
    exp_t e;
    do_clear();
    push("pipe_16th", 16'h0000, 1'b0, 1'b0);
    push("pipe_settle", 16'h0010, 1'b1, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) tick();
      e = sb.pop_front();
      n_tests += 2;
      if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
      if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    do_clear();
    load = 1'b1; load_value = 16'hFFFF;
    tick();
    load = 1'b0;
    push("wrap_e1", 16'hFFF0, 1'b0, 1'b0);
    push("wrap_e2", 16'hFF00, 1'b0, 1'b0);
    push("wrap_e3", 16'hF000, 1'b0, 1'b0);
    push("wrap_e4", 16'h0000, 1'b1, 1'b1);
    push("wrap_e5", 16'h0000, 1'b1, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      en = 1'b0;
      e = sb.pop_front();
      n_tests += 3;
      if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
      if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
      if (wrap !== e.wrap) begin n_fail++; $display("FAIL %s wrap got %b want %b", e.name, wrap, e.wrap); end
    end
`ifdef ACC_SEG_WRAP_COUNT_EN
    n_tests++;
    if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", wrap_count); end
`endif
  endtask

  task automatic test_continuous();
    exp_t e;
    int   wraps = 0;
    do_clear();
    push("continuous", 16'h1170, 1'b1, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (wrap === 1'b1) wraps++;
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wrap === 1'b1) wraps++;
    end
    e = sb.pop_front();
    n_tests += 4;
    if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
    if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
    if (wraps != 1) begin n_fail++; $display("FAIL continuous_wraps got %0d want 1", wraps); end
    if (msb !== 1'b0) begin n_fail++; $display("FAIL continuous_msb got %b want 0", msb); end
  endtask

  task automatic test_priority();
    exp_t e;
    load = 1'b1; load_value = 16'h4321;
    tick();
    push("prio_clr_wins", 16'h0000, 1'b1, 1'b0);
    push("prio_load_no_en", 16'h1234, 1'b1, 1'b0);
    push("prio_hold", 16'h1234, 1'b1, 1'b0);
    clr = 1'b1; load = 1'b1; load_value = 16'h1234; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      clr = 1'b0;
      if (k == 1) begin load = 1'b0; en = 1'b0; end
      e = sb.pop_front();
      n_tests += 2;
      if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
      if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_clear();
    load = 1'b1; load_value = 16'h00FF;
    tick();
    load = 1'b0;
    push("b2b_e1", 16'h00F0, 1'b0, 1'b0);
    push("b2b_e2", 16'h0001, 1'b0, 1'b0);
    push("b2b_e3", 16'h0102, 1'b1, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) en = 1'b0;
      e = sb.pop_front();
      n_tests += 2;
      if (data !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data, e.data); end
      if (settled !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled, e.settled); end
    end
  endtask

  task automatic test_add_width4();
    exp_t e;
    do_clear();
    push("aw4_e1", 16'h000F, 1'b1, 1'b0);
    push("aw4_e2", 16'h000E, 1'b0, 1'b0);
    push("aw4_settle", 16'h001E, 1'b1, 1'b0);
    add_value4 = 4'hF; en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (k == 1) en = 1'b0;
      e = sb.pop_front();
      n_tests += 2;
      if (data4 !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data4, e.data); end
      if (settled4 !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled4, e.settled); end
    end
    for (int k = 0; k < 3; k++) tick();
    e = sb.pop_front();
    n_tests += 2;
    if (data4 !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", e.name, data4, e.data); end
    if (settled4 !== e.settled) begin n_fail++; $display("FAIL %s settled got %b want %b", e.name, settled4, e.settled); end
    add_value4 = 4'h0;
  endtask

  initial begin
    test_reset();
    test_carry_pipeline();
    test_wrap();
    test_continuous();
    test_priority();
    test_back_to_back();
    test_add_width4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_seg.md
Name: accumulator_seg

Overview:
- Parametrised accumulator with a pipelined carry chain and a settle indicator.
- The accumulator is split into NSEG segments of SEG_WIDTH bits. Each segment has a registered carry into the next segment, so the critical path is one SEG_WIDTH adder regardless of total width.
- Replaces the ripple-carry accumulator behind the top-level MSB/tone output.
- Adds synchronous clear, parallel load, enable gating, a wrap pulse and a settled flag.

Parameters:
- SEG_WIDTH, 4, bits per segment; must be ≥ 1.
- NSEG, 4, number of segments; must be ≥ 2. ACC_WIDTH = SEG_WIDTH*NSEG is derived as a localparam.
- ADD_WIDTH, 1, width of add_value; must be ≤ SEG_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- en  in  1  accumulate add_value this cycle
- add_value  in  ADD_WIDTH  unsigned increment, zero-extended into segment 0
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_value  in  SEG_WIDTH*NSEG  value for load
- data  out  SEG_WIDTH*NSEG  concatenated segment registers, segment NSEG-1 at the MSBs
- msb  out  1  data[ACC_WIDTH-1]
- settled  out  1  high when no carry is pending (data is arithmetically exact)
- wrap  out  1  one-cycle pulse on carry-out of the top segment

Behaviour:
- Reset: rst_n low is an asynchronous, active-low reset. All segments, all carry registers and wrap go to 0. data = 0, msb = 0, settled = 1.
- Per-edge priority: clr > load > normal.
- clr: all segments, carries and wrap become 0.
- load: segment i takes load_value[i*SEG_WIDTH +: SEG_WIDTH]. All carries and wrap become 0. en is ignored that cycle.
- Normal operation, seg[i] and carry[i], i = 0..NSEG-2 are registers:
  - seg0 <= low SEG_WIDTH bits of seg0 + (en ? add_value : 0); carry0 <= carry-out of that sum.
  - For i ≥ 1: seg[i] <= seg[i] + carry[i-1]. For i < NSEG-1, carry[i] <= carry-out of that add.
  - wrap <= carry-out of the top segment.
- Every adder sums one segment plus at most one carry bit (or add_value ≤ SEG_WIDTH bits), so each carry is exactly 1 bit.
- Latency:
  - An enabled add changes seg0 at the same edge.
  - A carry from seg0 reaches seg[i] i edges later.
  - wrap rises NSEG-1 edges after the add that causes the overflow and lasts one cycle.
- settled = NOR of all carry registers; it is combinational from registers.
- Architectural value = data + Σ carry[i]·2^((i+1)·SEG_WIDTH), mod 2^ACC_WIDTH.
- After en stays low for NSEG-1 cycles, settled = 1 and data equals the exact modular sum.
- Simultaneous events: en may assert every cycle while carries are pending; no add is lost or stalled. Carries keep propagating independently.
- Wrap-around: the value wraps mod 2^ACC_WIDTH. No saturation.
- Reset mid-propagation discards pending carries; no wrap pulse is generated.

Optional Feature:
- Macro: ACC_SEG_WRAP_COUNT_EN.
- Defined:
  - Adds output port wrap_count[7:0], which increments on each wrap pulse and saturates at 255.
  - Cleared by rst_n and by clr; unaffected by load.
- Undefined: no wrap_count port and no counter logic. All other behaviour is identical.

Decomposition:
- Package acc_seg_pkg holds:
  - default constants ACC_SEG_DEF_SEG_WIDTH=4, ACC_SEG_DEF_NSEG=4, ACC_SEG_DEF_ADD_WIDTH=1;
  - the wrap_count width constant ACC_SEG_WRAP_CNT_W=8.
- Sub-module acc_seg_slice: one segment register plus its outgoing carry register, with clr/load/carry_in/add_in inputs. It is instantiated NSEG times by a generate loop. The top slice's carry output drives wrap.
- The top module holds the settled reduction and the optional wrap counter.

Test Plan:
All cases use defaults (ACC_WIDTH=16, SEG_WIDTH=4), add_value=1 unless stated.
- Reset: hold rst_n low mid-run with carries pending → data=0x0000, settled=1, wrap=0 immediately (asynchronous); no wrap after release.
- Carry pipeline: en high 16 cycles then low → data=0x0000 with settled=0 right after the 16th edge; one edge later data=0x0010 and settled=1.
- Wrap: load 0xFFFF, then en for 1 cycle → settled=0 for 3 cycles; wrap high exactly one cycle, 3 edges after the add; then data=0x0000 and settled=1. With ACC_SEG_WRAP_COUNT_EN, wrap_count=1.
- Continuous add: en high 70000 cycles, then 3 idle cycles → data=70000 mod 65536=0x1170, wrap pulsed exactly once, msb=0.
- Priority: clr, load(0x1234) and en all high on the same cycle → data=0x0000. Then load(0x1234) with en high → data=0x1234, not 0x1235.
- ADD_WIDTH=4: add_value=0xF for 2 cycles from 0 → data=0x001E after settling (seg0=0xE, seg1=0x1).
